// File: rtl/irq_pkg.sv
// Shared constants and FSM encoding for the interrupt controller.
package irq_pkg;
  localparam int unsigned N_SRC      = 4;
  localparam logic [31:0] BASE_ADDR  = 32'h4000_0030;
  localparam logic [31:0] OFF_IMASK  = 32'h0;
  localparam logic [31:0] OFF_IPEND  = 32'h4;
  localparam logic [31:0] OFF_ICAUSE = 32'h8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_SERVICE
  } state_t;
endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: the lowest set index wins.
module irq_prio_enc #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     pend,
  output logic             any,
  output logic [IDX_W-1:0] index
);

  always_comb begin
    any   = 1'b0;
    index = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (pend[i] && !any) begin
        any   = 1'b1;
        index = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: edge-latched pending bits, mask,
// fixed priority, and a single-level request/service handshake with the CPU.
module irq_controller #(
  parameter int unsigned N_SRC     = irq_pkg::N_SRC,
  parameter logic [31:0] BASE_ADDR = irq_pkg::BASE_ADDR
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             ker,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic [31:0]      Address,
  input  logic [31:0]      WriteData,
  output logic [31:0]      ReadData,
  output logic             IRQ
);
  import irq_pkg::*;

  localparam int unsigned IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [N_SRC-1:0] imask, ipend, src_q;
  logic [N_SRC-1:0] rise, w1c, svc_clr, masked;
  logic             cause_valid;
  logic [IDX_W-1:0] cause_idx;
  logic             any;
  logic [IDX_W-1:0] win_idx;
  logic             load_cause, drop_valid;
  logic             sel_imask, sel_ipend, sel_icause;
  logic             unused_wdata;
  state_t           state, state_nxt;

  assign sel_imask    = (Address == BASE_ADDR + OFF_IMASK);
  assign sel_ipend    = (Address == BASE_ADDR + OFF_IPEND);
  assign sel_icause   = (Address == BASE_ADDR + OFF_ICAUSE);
  assign unused_wdata = ^WriteData;

  assign rise    = irq_src & ~src_q;
  assign masked  = ipend & imask;
  assign w1c     = (MemWrite && sel_ipend) ? WriteData[N_SRC-1:0] : '0;
  assign svc_clr = load_cause ? (N_SRC'(1) << win_idx) : '0;

  irq_prio_enc #(
    .N     (N_SRC),
    .IDX_W (IDX_W)
  ) u_prio (
    .pend  (masked),
    .any   (any),
    .index (win_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      imask       <= '0;
      ipend       <= '0;
      src_q       <= '0;
      cause_valid <= 1'b0;
      cause_idx   <= '0;
    end else begin
      state <= state_nxt;
      src_q <= irq_src;
      if (MemWrite && sel_imask) imask <= WriteData[N_SRC-1:0];
      // New edges are OR'd in last so they survive a same-cycle clear.
      ipend <= (ipend & ~w1c & ~svc_clr) | rise;
      if (load_cause) begin
        cause_valid <= 1'b1;
        cause_idx   <= win_idx;
      end else if (drop_valid) begin
        cause_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    load_cause = 1'b0;
    drop_valid = 1'b0;
    case (state)
      ST_IDLE:    if (any && !ker) state_nxt = ST_REQ;
      ST_REQ: begin
        if (ker && any) begin
          state_nxt  = ST_SERVICE;
          load_cause = 1'b1;
        end else if (!any) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (!ker) begin
          state_nxt  = ST_IDLE;
          drop_valid = 1'b1;
        end
      end
      default:    state_nxt = ST_IDLE;
    endcase
  end

  assign IRQ = (state == ST_REQ);

  always_comb begin
    ReadData = '0;
    if (!reset && MemRead) begin
      if (sel_imask)       ReadData = 32'(imask);
      else if (sel_ipend)  ReadData = 32'(ipend);
      else if (sel_icause) ReadData = {cause_valid, {(31 - IDX_W){1'b0}}, cause_idx};
    end
  end

endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 Parameter N_SRC SHALL default to 4 and set the number of interrupt sources; bit 0 has highest priority.
REQ-002 Parameter BASE_ADDR SHALL default to 32'h4000_0030 and set the base of the three-word register window.
REQ-003 clk  in  1  single system clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 irq_src  in  N_SRC  level interrupt lines from peripherals (timer, UART RX, UART TX, switches).
REQ-006 ker  in  1  CPU kernel-mode flag (PC[31]); high while the handler runs.
REQ-007 MemRead  in  1  CPU load strobe.
REQ-008 MemWrite  in  1  CPU store strobe.
REQ-009 Address  in  32  CPU byte address.
REQ-010 WriteData  in  32  CPU store data.
REQ-011 ReadData  out  32  register read data; 0 when not selected.
REQ-012 IRQ  out  1  interrupt request to the CPU control unit.

Function
REQ-013 Registers: IMASK at BASE+0 (R/W, bits [N_SRC-1:0]); IPEND at BASE+4 (R; write-1-to-clear); ICAUSE at BASE+8 (R only; bit 31 valid, bits [1:0] source index).
REQ-014 ReadData SHALL be combinational: value of the addressed register, zero-extended, when MemRead=1 and Address is in the window; otherwise 0.
REQ-015 IMASK, IPEND and ICAUSE writes SHALL take effect on the clock edge on which MemWrite=1; writes to ICAUSE or unmapped offsets SHALL be ignored.
REQ-016 IPEND[i] SHALL set on the cycle after a rising edge of irq_src[i] (edge detected against a 1-cycle registered copy).
REQ-017 If a set and a write-1-clear hit the same IPEND bit in one cycle, set SHALL win.
REQ-018 Masked pending (IPEND & IMASK) SHALL be reduced by a fixed-priority encoder: lowest index wins.
REQ-019 FSM states: IDLE, REQ, SERVICE.
REQ-020 IDLE->REQ when masked pending != 0 and ker=0; IDLE SHALL hold while ker=1 (exception handler in progress).
REQ-021 IRQ SHALL be 1 exactly in REQ, registered, so it rises one cycle after entry conditions hold.
REQ-022 REQ->IDLE if masked pending becomes 0 (mask or clear) before ker rises; IRQ drops that cycle.
REQ-023 REQ->SERVICE on the first cycle ker=1; on that edge ICAUSE SHALL load {valid=1, winning index} and that IPEND bit SHALL clear (unless re-set per REQ-017).
REQ-024 SERVICE->IDLE on the first cycle ker=0 (handler return); ICAUSE valid SHALL clear on that edge; other pending sources re-enter REQ no earlier than the following cycle.
REQ-025 Events arriving during SERVICE SHALL only set IPEND; no nesting.

Reset
REQ-026 On reset=1 at a clock edge: state=IDLE, IRQ=0, IMASK=0, IPEND=0, ICAUSE=0, edge-detect registers=0.
REQ-027 Reset during REQ or SERVICE SHALL abandon the request with no residual pending or cause.
REQ-028 ReadData SHALL be 0 while reset=1.

Structure
REQ-029 Shared package irq_pkg SHALL hold N_SRC, BASE_ADDR, register offsets (0, 4, 8) and the FSM state encoding.
REQ-030 Priority encoding SHALL be a sub-module irq_prio_enc (inputs masked pending; outputs any, index).
REQ-031 Total RTL target: 150-300 lines; no multi-clock logic.

Verification
REQ-032 IMASK=4'b0001, pulse irq_src[0] -> IPEND=1 next cycle, IRQ=1 one cycle later; raise ker -> IRQ=0, ICAUSE=32'h8000_0000, IPEND=0.
REQ-033 IMASK=4'b1111, rising edges on src[3] and src[1] in the same cycle -> ICAUSE index=1; after ker falls, IRQ reasserts, second service gives index=3.
REQ-034 In REQ, write IMASK=0 -> IRQ=0 next cycle, state IDLE, IPEND unchanged.
REQ-035 Write IPEND=4'b0100 in the same cycle src[2] rises -> IPEND[2] remains 1.
REQ-036 Assert reset while in SERVICE with IPEND=4'b1010 -> next cycle IRQ=0, IPEND=0, ICAUSE=0, IMASK=0; ReadData of BASE+4 reads 0.
